en_pulse_gen: RTL and testbench

- Parametrised, multi-channel successor to the fixed-rate enable generator in the stopwatch datapath.
- Produces N_CH independent one-cycle enable pulses from clk_100mhz. Each channel's divisor is reset-initialised by parameter and can be reprogrammed at run time.
- Divisor changes take effect glitch-free at the channel's next terminal count.
- Global run/pause and a phase-align restart are provided for the display, blink and tick logic.

---
 rtl/en_pulse_gen.sv | 116 +++++++++++
 tb/tb_en_pulse_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/en_pulse_gen.sv
// en_pulse_gen: N_CH independent one-cycle enable pulses derived from clk_100mhz.
// Each channel is a down-counter reloaded from its active divisor. A run-time
// divisor write parks in a shadow register and is adopted at the next terminal
// count, or at a sync strobe. This keeps the current period intact.
// Optional build macro: EN_PULSE_TOGGLE_EN adds tog_out, a per-channel square
// wave that flips on every enable pulse.
module en_pulse_gen #(
  parameter int                 N_CH     = 4,
  parameter int                 CW       = 27,
  parameter logic [N_CH*CW-1:0] DIV_INIT = {27'd66_666_666, 27'd262_144,
                                            27'd50_000_000, 27'd100_000_000}
) (
  input  logic                     clk_100mhz,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     sync,
  input  logic                     cfg_we,
  input  logic [$clog2(N_CH)-1:0]  cfg_ch,
  input  logic [CW-1:0]            cfg_div,
  output logic [N_CH-1:0]          en_out,
`ifdef EN_PULSE_TOGGLE_EN
  output logic [N_CH-1:0]          tog_out,
`endif
  output logic [N_CH-1:0]          cfg_pend
);

  localparam int CHW = $clog2(N_CH);

  // Reload value for a divisor: a divisor of 0 behaves like 1 (pulse every cycle).
  function automatic logic [CW-1:0] eff_m1(input logic [CW-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [CHW-1:0] CH_IDX   = CHW'(gi);
    localparam logic [CW-1:0]  INIT_DIV = DIV_INIT[gi*CW +: CW];
    localparam logic [CW-1:0]  INIT_CNT = eff_m1(INIT_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] shd_q, shd_d;
    logic [CW-1:0] nxt_div;
    logic          pend_q, pend_d;
    logic          en_q, en_d;
    logic          wr_hit;
    logic          reload;
`ifdef EN_PULSE_TOGGLE_EN
    logic          tog_q, tog_d;
`endif

    // Next-state: sync beats terminal count. A write that lands on a reload
    // cycle is adopted directly, so it never shows up as pending.
    always_comb begin
      wr_hit  = cfg_we && (cfg_ch == CH_IDX);
      nxt_div = wr_hit ? cfg_div : (pend_q ? shd_q : act_q);
      reload  = sync || (run && (cnt_q == '0));
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      en_d    = 1'b0;
`ifdef EN_PULSE_TOGGLE_EN
      tog_d   = tog_q;
`endif
      if (wr_hit) begin
        shd_d = cfg_div;
      end
      if (reload) begin
        cnt_d  = eff_m1(nxt_div);
        act_d  = nxt_div;
        pend_d = 1'b0;
        en_d   = !sync;
`ifdef EN_PULSE_TOGGLE_EN
        tog_d  = sync ? 1'b0 : !tog_q;
`endif
      end else begin
        if (wr_hit) begin
          pend_d = 1'b1;
        end
        if (run) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    // Channel state registers; reset restores the build-time divisor.
    always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
        cnt_q  <= INIT_CNT;
        act_q  <= INIT_DIV;
        shd_q  <= '0;
        pend_q <= 1'b0;
        en_q   <= 1'b0;
`ifdef EN_PULSE_TOGGLE_EN
        tog_q  <= 1'b0;
`endif
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        en_q   <= en_d;
`ifdef EN_PULSE_TOGGLE_EN
        tog_q  <= tog_d;
`endif
      end
    end

    assign en_out[gi]   = en_q;
    assign cfg_pend[gi] = pend_q;
`ifdef EN_PULSE_TOGGLE_EN
    assign tog_out[gi]  = tog_q;
`endif
  end

endmodule

// File: tb/tb_en_pulse_gen.sv
// Bench for en_pulse_gen: a hand-derived vector table, a behavioural phase model
// feeding a scoreboard queue, plus async-reset and out-of-range-channel sequences.
module tb_en_pulse_gen;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam logic [N*CW-1:0] INIT  = {8'd1, 8'd2, 8'd3, 8'd4};  // ch0=4 ch1=3 ch2=2 ch3=1
  localparam logic [3*CW-1:0] INIT3 = {8'd2, 8'd2, 8'd2};

  logic          clk = 1'b0;
  logic          rst, run, sync, cfg_we;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [N-1:0]  en_out, cfg_pend;
  logic          rst3, run3, sync3, we3;
  logic [1:0]    ch3;
  logic [CW-1:0] div3;
  logic [2:0]    en3, pend3;
`ifdef EN_PULSE_TOGGLE_EN
  logic [N-1:0]  tog_out;
  logic [2:0]    tog3;
`endif

  always #5 clk = ~clk;

  en_pulse_gen #(.N_CH(N), .CW(CW), .DIV_INIT(INIT)) dut (
    .clk_100mhz(clk), .rst(rst), .run(run), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .en_out(en_out),
`ifdef EN_PULSE_TOGGLE_EN
    .tog_out(tog_out),
`endif
    .cfg_pend(cfg_pend));

  en_pulse_gen #(.N_CH(3), .CW(CW), .DIV_INIT(INIT3)) dut3 (
    .clk_100mhz(clk), .rst(rst3), .run(run3), .sync(sync3), .cfg_we(we3),
    .cfg_ch(ch3), .cfg_div(div3), .en_out(en3),
`ifdef EN_PULSE_TOGGLE_EN
    .tog_out(tog3),
`endif
    .cfg_pend(pend3));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model: elapsed-phase per channel ----------------
  int m_act[N], m_shd[N], m_ph[N];
  bit m_pend[N], m_en[N], m_tog[N];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    logic [N*CW-1:0] iv;
    iv = INIT;
    for (int i = 0; i < N; i++) begin
      m_act[i] = int'(iv[i*CW +: CW]);
      m_shd[i] = 0; m_ph[i] = 0;
      m_pend[i] = 0; m_en[i] = 0; m_tog[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit w, input int c, input int d);
    for (int i = 0; i < N; i++) begin
      bit wr;
      int nxt;
      wr  = w && (c == i);
      nxt = wr ? d : (m_pend[i] ? m_shd[i] : m_act[i]);
      if (s) begin
        m_act[i] = nxt; m_ph[i] = 0; m_pend[i] = 0; m_en[i] = 0; m_tog[i] = 0;
        if (wr) m_shd[i] = d;
      end else if (r && (m_ph[i] + 1 == eff(m_act[i]))) begin
        m_act[i] = nxt; m_ph[i] = 0; m_pend[i] = 0; m_en[i] = 1; m_tog[i] = !m_tog[i];
        if (wr) m_shd[i] = d;
      end else begin
        m_en[i] = 0;
        if (r) m_ph[i]++;
        if (wr) begin m_shd[i] = d; m_pend[i] = 1; end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] pend;
    logic [N-1:0] tog;
    string        tag;
  } exp_t;
  exp_t sbq[$];

  task automatic step(input bit r, input bit s, input bit w, input logic [1:0] c,
                      input logic [CW-1:0] d, input string tag);
    exp_t e;
    run = r; sync = s; cfg_we = w; cfg_ch = c; cfg_div = d;
    model_step(r, s, w, int'(c), int'(d));
    for (int i = 0; i < N; i++) begin
      e.en[i] = m_en[i]; e.pend[i] = m_pend[i]; e.tog[i] = m_tog[i];
    end
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    check({e.tag, " en_out"}, int'(en_out), int'(e.en));
    check({e.tag, " cfg_pend"}, int'(cfg_pend), int'(e.pend));
`ifdef EN_PULSE_TOGGLE_EN
    check({e.tag, " tog_out"}, int'(tog_out), int'(e.tog));
`endif
    cfg_we = 1'b0; sync = 1'b0;
  endtask

  // ---------------- hand-derived vector table ----------------
  typedef struct {
    bit            run, sync, we;
    logic [1:0]    ch;
    logic [CW-1:0] div;
    int            n;
    logic [3:0]    exp_en, exp_pend;
  } vec_t;
  vec_t tbl[21];

  initial begin
    // Edge counts below are rising edges since reset release.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 2, 4'b1100, 4'b0000}; // edge 2
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1, 4'b1010, 4'b0000}; // edge 3: ch1 first
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1, 4'b1101, 4'b0000}; // edge 4: ch0 first
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8, 4'b1111, 4'b0000}; // edge 12
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1, 4'b1000, 4'b0000}; // edge 13: ch0 cnt=2
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 5, 4'b0000, 4'b0000}; // pause 5
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3, 4'b1101, 4'b0000}; // ch0 3 after resume
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd6, 1, 4'b1000, 4'b0001}; // deferred write
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 2, 4'b1000, 4'b0001};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1, 4'b1101, 4'b0000}; // old period 4 kept
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 6, 4'b1101, 4'b0000}; // new period 6
    tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd5, 1, 4'b1010, 4'b0000}; // collision ch1
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 5, 4'b1111, 4'b0000}; // ch1 period 5
    tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1, 4'b0000, 4'b0000}; // sync, run=0
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1, 4'b1000, 4'b0000};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'd0, 1, 4'b1100, 4'b0000}; // ch2 div=0
    tbl[16] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3, 4'b1110, 4'b0000}; // ch2 every cycle
    tbl[17] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd4, 1, 4'b1101, 4'b0010}; // pending ch1
    tbl[18] = '{1'b1, 1'b1, 1'b1, 2'd0, 8'd3, 1, 4'b0000, 4'b0000}; // sync + write
    tbl[19] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3, 4'b1101, 4'b0000}; // ch0 period 3
    tbl[20] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1, 4'b1110, 4'b0000}; // ch1 period 4

    rst = 1'b1; run = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    rst3 = 1'b1; run3 = 1'b0; sync3 = 1'b0; we3 = 1'b0; ch3 = '0; div3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset en_out", int'(en_out), 0);
    check("reset cfg_pend", int'(cfg_pend), 0);
`ifdef EN_PULSE_TOGGLE_EN
    check("reset tog_out", int'(tog_out), 0);
`endif
    rst = 1'b0;
    model_reset();

    for (int k = 0; k < 21; k++) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        // Only the first cycle of a multi-cycle entry carries its write/sync.
        step(tbl[k].run, (j == 0) && tbl[k].sync, (j == 0) && tbl[k].we,
             tbl[k].ch, tbl[k].div, $sformatf("v%0d.%0d", k, j));
      end
      check($sformatf("v%0d hand en", k), int'(en_out), int'(tbl[k].exp_en));
      check($sformatf("v%0d hand pend", k), int'(cfg_pend), int'(tbl[k].exp_pend));
    end

    // Async reset mid-period with a pending write, asserted between edges.
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'd7, "pre-rst write");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst en_out", int'(en_out), 0);
    check("async rst cfg_pend", int'(cfg_pend), 0);
`ifdef EN_PULSE_TOGGLE_EN
    check("async rst tog_out", int'(tog_out), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int j = 0; j < 9; j++) step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, $sformatf("post-rst %0d", j + 1));

    // Three-channel instance: a write to channel 3 must be ignored.
    @(posedge clk); #1;
    rst3 = 1'b0; run3 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      we3 = (k == 3); ch3 = 2'd3; div3 = 8'd5;
      @(posedge clk); #1;
      check($sformatf("n3 edge%0d en", k), int'(en3), (k % 2 == 0) ? 7 : 0);
      check($sformatf("n3 edge%0d pend", k), int'(pend3), 0);
`ifdef EN_PULSE_TOGGLE_EN
      check($sformatf("n3 edge%0d tog", k), int'(tog3), ((k / 2) % 2 == 1) ? 7 : 0);
`endif
    end
    we3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
